// File: rtl/module_mult_seq.sv
// Keypad calculator sequencer: captures operand A then B, runs a fixed-latency
// shift-add multiply and drives the display source select.
module module_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_in,
    input  logic [WIDTH-1:0]   num_in,
    input  logic               clear,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               busy,
    output logic               done,
    output logic               rdy_drop,
    output logic [1:0]         fuente_sel
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_WAIT_A = 2'd0,
        S_WAIT_B = 2'd1,
        S_MULT   = 2'd2,
        S_SHOW   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [PW-1:0]     p_q, p_d;
    logic [PW-1:0]     mc_q, mc_d;
    logic [WIDTH-1:0]  mp_q, mp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [1:0]        sel_q, sel_d;
    logic [PW-1:0]     p_step;
    logic              last_iter;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_iter = (cnt_q == CNT_LAST);

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_WAIT_A;
        end else begin
            unique case (state_q)
                S_WAIT_A: if (rdy_in) state_d = S_WAIT_B;
                S_WAIT_B: if (rdy_in) state_d = S_MULT;
                S_MULT:   if (last_iter) state_d = S_SHOW;
                S_SHOW:   if (rdy_in) state_d = S_WAIT_B;
                default:  state_d = S_WAIT_A;
            endcase
        end
    end

    // Partial product for the current iteration
    assign p_step = mp_q[0] ? (p_q + mc_q) : p_q;

    // Datapath and output next-values
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        p_d    = p_q;
        mc_d   = mc_q;
        mp_d   = mp_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        drop_d = 1'b0;
        busy_d = (state_d == S_MULT);
        unique case (state_d)
            S_MULT:  sel_d = 2'b01;
            S_SHOW:  sel_d = 2'b10;
            default: sel_d = 2'b00;
        endcase

        if (clear) begin
            a_d    = '0;
            b_d    = '0;
            prod_d = '0;
            p_d    = '0;
            mc_d   = '0;
            mp_d   = '0;
            cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_WAIT_A: begin
                    if (rdy_in) a_d = num_in;
                end
                S_WAIT_B: begin
                    if (rdy_in) begin
                        b_d   = num_in;
                        p_d   = '0;
                        mc_d  = {{WIDTH{1'b0}}, a_q};
                        mp_d  = num_in;
                        cnt_d = '0;
                    end
                end
                S_MULT: begin
                    p_d    = p_step;
                    mc_d   = mc_q << 1;
                    mp_d   = mp_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    drop_d = rdy_in;
                    if (last_iter) begin
                        prod_d = p_step;
                        done_d = 1'b1;
                    end
                end
                S_SHOW: begin
                    if (rdy_in) begin
                        a_d = num_in;
                        b_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            p_q    <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
            sel_q  <= 2'b00;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            p_q    <= p_d;
            mc_q   <= mc_d;
            mp_q   <= mp_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            drop_q <= drop_d;
            sel_q  <= sel_d;
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign prod_o     = prod_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rdy_drop   = drop_q;
    assign fuente_sel = sel_q;

endmodule

// File: tb/tb_module_mult_seq.sv
// Scoreboard bench for module_mult_seq: stimulus pushes expected products,
// a monitor pops and checks them on every done pulse.
module tb_module_mult_seq;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               rdy_in;
    logic [WIDTH-1:0]   num_in;
    logic               clear;
    logic [WIDTH-1:0]   a_o;
    logic [WIDTH-1:0]   b_o;
    logic [2*WIDTH-1:0] prod_o;
    logic               busy;
    logic               done;
    logic               rdy_drop;
    logic [1:0]         fuente_sel;

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] prod;
        int unsigned        cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_err;
    int unsigned cyc;
    int          n_done;
    logic        prev_done;
    logic        prev_drop;

    module_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .num_in     (num_in),
        .clear      (clear),
        .a_o        (a_o),
        .b_o        (b_o),
        .prod_o     (prod_o),
        .busy       (busy),
        .done       (done),
        .rdy_drop   (rdy_drop),
        .fuente_sel (fuente_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: pop the scoreboard on every done and check pulse widths
    initial begin
        n_done    = 0;
        prev_done = 1'b0;
        prev_drop = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                exp_t e;
                n_done++;
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("prod_o", 32'(prod_o), 32'(e.prod));
                    check("a_o_at_done", 32'(a_o), 32'(e.a));
                    check("b_o_at_done", 32'(b_o), 32'(e.b));
                    check("done_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (rdy_drop) check("rdy_drop_single_cycle", 32'(prev_drop), 32'd0);
            prev_done = done;
            prev_drop = rdy_drop;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [WIDTH-1:0] v);
        rdy_in = 1'b1;
        num_in = v;
        step();
        rdy_in = 1'b0;
    endtask

    // Enter operand B and register the expected product WIDTH edges later
    task automatic enter_b(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2*WIDTH-1:0] p);
        exp_t e;
        enter(b);
        e.a    = a;
        e.b    = b;
        e.prod = p;
        e.cyc  = cyc + WIDTH;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 30) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int nd;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b0;
        rdy_in = 1'b0;
        num_in = '0;
        clear  = 1'b0;
        #3;
        check("rst_a_o", 32'(a_o), 32'd0);
        check("rst_prod_o", 32'(prod_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(fuente_sel), 32'd0);
        step();
        rst = 1'b1;
        step();

        // 1: 12 * 13, select sequence
        check("t1_sel_wait_a", 32'(fuente_sel), 32'd0);
        enter(8'd12);
        check("t1_a_o", 32'(a_o), 32'd12);
        check("t1_sel_wait_b", 32'(fuente_sel), 32'd0);
        enter_b(8'd12, 8'd13, 16'd156);
        check("t1_sel_mult", 32'(fuente_sel), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done();
        check("t1_sel_show", 32'(fuente_sel), 32'd2);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: max operands, then zero multiplicand
        enter(8'd255);
        check("t2_b_cleared", 32'(b_o), 32'd0);
        enter_b(8'd255, 8'd255, 16'hFE01);
        wait_done();
        enter(8'd0);
        enter_b(8'd0, 8'd200, 16'd0);
        wait_done();

        // 3: rdy_in during third MULT cycle is dropped
        enter(8'd5);
        enter_b(8'd5, 8'd9, 16'd45);
        step();
        step();
        rdy_in = 1'b1;
        num_in = 8'd77;
        step();
        rdy_in = 1'b0;
        check("t3_rdy_drop", 32'(rdy_drop), 32'd1);
        check("t3_a_o_kept", 32'(a_o), 32'd5);
        check("t3_b_o_kept", 32'(b_o), 32'd9);
        step();
        check("t3_rdy_drop_low", 32'(rdy_drop), 32'd0);
        wait_done();

        // 4: new A from SHOW keeps last product until next done
        enter(8'd7);
        check("t4_a_o", 32'(a_o), 32'd7);
        check("t4_b_o", 32'(b_o), 32'd0);
        check("t4_sel", 32'(fuente_sel), 32'd0);
        check("t4_prod_hold", 32'(prod_o), 32'd45);
        step();
        step();
        enter_b(8'd7, 8'd3, 16'd21);
        step();
        step();
        step();
        step();
        check("t4_prod_hold_mult", 32'(prod_o), 32'd45);
        wait_done();

        // 5: clear mid-MULT, then clear racing rdy_in
        enter(8'd6);
        enter(8'd11);
        step();
        step();
        step();
        nd = n_done;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_a_o", 32'(a_o), 32'd0);
        check("t5_b_o", 32'(b_o), 32'd0);
        check("t5_prod_o", 32'(prod_o), 32'd0);
        check("t5_sel", 32'(fuente_sel), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("t5_no_done", 32'(n_done), 32'(nd));
        clear  = 1'b1;
        rdy_in = 1'b1;
        num_in = 8'd99;
        step();
        clear  = 1'b0;
        rdy_in = 1'b0;
        check("t5_clear_wins_a", 32'(a_o), 32'd0);
        check("t5_clear_no_drop", 32'(rdy_drop), 32'd0);

        // rdy_in on the completing edge is dropped and SHOW still entered
        enter(8'd2);
        enter_b(8'd2, 8'd3, 16'd6);
        for (int i = 0; i < WIDTH - 1; i++) step();
        rdy_in = 1'b1;
        num_in = 8'd50;
        step();
        rdy_in = 1'b0;
        check("t5_edge_drop", 32'(rdy_drop), 32'd1);
        check("t5_edge_sel", 32'(fuente_sel), 32'd2);
        check("t5_edge_a_o", 32'(a_o), 32'd2);
        wait_done();

        // 6: async reset between edges aborts MULT
        enter(8'd12);
        enter(8'd13);
        step();
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        check("t6_a_o", 32'(a_o), 32'd0);
        check("t6_b_o", 32'(b_o), 32'd0);
        check("t6_prod_o", 32'(prod_o), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_sel", 32'(fuente_sel), 32'd0);
        #2;
        rst = 1'b1;
        step();
        enter(8'd12);
        enter_b(8'd12, 8'd13, 16'd156);
        wait_done();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
